// File: rtl/clk_uart_pkg.sv
// Shared constants for the clock-to-UART time line sequencer:
// ASCII codes, the line length and the scheduler state encoding.
package clk_uart_pkg;

    localparam logic [7:0] ZERO  = 8'h30;
    localparam logic [7:0] TWO   = 8'h32;
    localparam logic [7:0] DASH  = 8'h2D;
    localparam logic [7:0] SPACE = 8'h20;
    localparam logic [7:0] COLON = 8'h3A;
    localparam logic [7:0] CR    = 8'h0D;
    localparam logic [7:0] LF    = 8'h0A;
    localparam logic [7:0] QMARK = 8'h3F;

    localparam int LINE_MAX = 18;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_SEND = 3'd2;
    localparam logic [2:0] ST_GAP  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    typedef enum logic [2:0] {
        IDLE = ST_IDLE,
        LOAD = ST_LOAD,
        SEND = ST_SEND,
        GAP  = ST_GAP,
        DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/bin2ascii2.sv
// Converts a 7-bit binary field into two ASCII decimal digits.
// Values above 99 cannot be shown in two digits and become "??".
module bin2ascii2
    import clk_uart_pkg::*;
(
    input  logic [6:0] bin,
    output logic [7:0] tens,
    output logic [7:0] ones
);

    logic [6:0] quot;
    logic [6:0] rem;

    always_comb begin
        quot = bin / 7'd10;
        rem  = bin % 7'd10;
        if (bin > 7'd99) begin
            tens = QMARK;
            ones = QMARK;
        end else begin
            tens = ZERO + {1'b0, quot};
            ones = ZERO + {1'b0, rem};
        end
    end

endmodule

// File: rtl/time_msg_scheduler.sv
// Snapshots the time fields on a minute rollover or manual request and streams
// "20YY-MM-DD HH:MM\r\n" byte by byte to a UART over a valid/ready handshake.
module time_msg_scheduler
    import clk_uart_pkg::*;
#(
    parameter bit AUTO_MINUTE = 1'b1,
    parameter bit EOL_CRLF    = 1'b1,
    parameter int GAP_CYCLES  = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] sec,
    input  logic [6:0] min,
    input  logic [6:0] hour,
    input  logic [6:0] day,
    input  logic [6:0] month,
    input  logic [6:0] year,
    input  logic       send_req,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       overrun,
    output logic [2:0] dbg_state
);

    localparam logic [4:0] LAST_IDX = EOL_CRLF ? 5'd17 : 5'd16;
    localparam bit         HAS_GAP  = (GAP_CYCLES != 0);
    localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 1);

    state_t     state, state_next;
    logic [6:0] sec_prev;
    logic       pending;
    logic [4:0] idx;
    logic [7:0] gap_cnt;
    logic       trig;
    logic       capture;
    logic       in_flight;

    logic [6:0] snap_sec, snap_min, snap_hour, snap_day, snap_month, snap_year;
    logic [7:0] byte_buf [LINE_MAX];
    logic [7:0] min_t, min_o, hour_t, hour_o, day_t, day_o;
    logic [7:0] month_t, month_o, year_t, year_o;
    logic [7:0] unused_sec_t, unused_sec_o;

    // Handshake: tx_valid is high only in SEND, tx_data comes from the loaded
    // buffer and cannot change until a cycle with tx_valid && tx_ready.
    assign tx_valid  = (state == SEND);
    assign tx_data   = (state == SEND) ? byte_buf[idx] : 8'h00;
    assign done      = (state == DONE);
    assign dbg_state = state;

    assign trig      = send_req | (AUTO_MINUTE & (sec == 7'd0) & (sec_prev != 7'd0));
    assign in_flight = (state == LOAD) || (state == SEND) || (state == GAP);
    assign capture   = ((state == IDLE) && trig) || ((state == DONE) && (pending || trig));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (trig) state_next = LOAD;
            LOAD: state_next = SEND;
            SEND: begin
                if (tx_ready) begin
                    if (idx == LAST_IDX) state_next = DONE;
                    else if (HAS_GAP)    state_next = GAP;
                end
            end
            GAP:  if (gap_cnt == 8'd0) state_next = SEND;
            DONE: state_next = (pending || trig) ? LOAD : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sec_prev <= '0;
            pending  <= 1'b0;
            busy     <= 1'b0;
            overrun  <= 1'b0;
            idx      <= '0;
            gap_cnt  <= '0;
        end else begin
            sec_prev <= sec;
            overrun  <= 1'b0;
            if (capture) busy <= 1'b1;
            case (state)
                LOAD: idx <= '0;
                SEND: begin
                    if (tx_ready && idx != LAST_IDX) begin
                        idx     <= idx + 5'd1;
                        gap_cnt <= GAP_LOAD;
                    end
                end
                GAP:  if (gap_cnt != 8'd0) gap_cnt <= gap_cnt - 8'd1;
                DONE: begin
                    pending <= 1'b0;
                    if (!(pending || trig)) busy <= 1'b0;
                end
                default: ;
            endcase
            // One request can wait behind the current line; any more are dropped.
            if (trig && in_flight) begin
                if (pending) overrun <= 1'b1;
                else         pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            snap_sec   <= sec;
            snap_min   <= min;
            snap_hour  <= hour;
            snap_day   <= day;
            snap_month <= month;
            snap_year  <= year;
        end
        if (state == LOAD) begin
            byte_buf[0]  <= TWO;
            byte_buf[1]  <= ZERO;
            byte_buf[2]  <= year_t;
            byte_buf[3]  <= year_o;
            byte_buf[4]  <= DASH;
            byte_buf[5]  <= month_t;
            byte_buf[6]  <= month_o;
            byte_buf[7]  <= DASH;
            byte_buf[8]  <= day_t;
            byte_buf[9]  <= day_o;
            byte_buf[10] <= SPACE;
            byte_buf[11] <= hour_t;
            byte_buf[12] <= hour_o;
            byte_buf[13] <= COLON;
            byte_buf[14] <= min_t;
            byte_buf[15] <= min_o;
            byte_buf[16] <= EOL_CRLF ? CR : LF;
            byte_buf[17] <= LF;
        end
    end

    // Seconds are converted alongside the other fields but never appear in the line.
    bin2ascii2 u_sec   (.bin(snap_sec),   .tens(unused_sec_t), .ones(unused_sec_o));
    bin2ascii2 u_min   (.bin(snap_min),   .tens(min_t),        .ones(min_o));
    bin2ascii2 u_hour  (.bin(snap_hour),  .tens(hour_t),       .ones(hour_o));
    bin2ascii2 u_day   (.bin(snap_day),   .tens(day_t),        .ones(day_o));
    bin2ascii2 u_month (.bin(snap_month), .tens(month_t),      .ones(month_o));
    bin2ascii2 u_year  (.bin(snap_year),  .tens(year_t),       .ones(year_o));

endmodule
